mips_regfile_param: RTL

Parametrised general-purpose register file for the single-cycle MIPS datapath, succeeding the fixed 32×32 two-read/one-write file. Width and register count are generic. It supports byte-enabled writes, asynchronous clear, and a per-register pending scoreboard so multi-cycle producers (loads, mul/div) can reserve a destination. An optional compile-time write-to-read bypass is available. Sits between decode (read addresses, reservations) and writeback (write port).

---
 rtl/mips_regfile_param.sv | 103 ++++++++++
 1 files changed

// File: rtl/mips_regfile_param.sv
// Parametrised MIPS register file: byte-enabled write, pending scoreboard, async clear.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module mips_regfile_param #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Rs_addr,
  input  logic [ADDR_W-1:0] Rt_addr,
  input  logic [ADDR_W-1:0] Rd_addr,
  input  logic [DATA_W-1:0] Rd_in,
  input  logic [BE_W-1:0]   Rd_Byte_w_en,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] Rs_out_wire,
  output logic [DATA_W-1:0] Rt_out_wire,
  output logic              rs_rdy,
  output logic              rt_rdy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pending;
  logic [ADDR_W:0]   r_pend_cnt;

  logic              w_wr_valid;
  logic              w_rsv_valid;
  logic [DATA_W-1:0] w_wr_mask;
  logic [NREG-1:0]   w_pend_next;
  logic [ADDR_W:0]   w_cnt_next;
  logic [DATA_W-1:0] w_rs_stored;
  logic [DATA_W-1:0] w_rt_stored;
  logic              w_rs_rdy_stored;
  logic              w_rt_rdy_stored;

  assign w_wr_valid  = (Rd_addr != '0) && (|Rd_Byte_w_en);
  assign w_rsv_valid = rsv_en && (rsv_addr != '0);

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_mask
      assign w_wr_mask[8*gi +: 8] = {8{Rd_Byte_w_en[gi]}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_valid) begin
      r_regs[Rd_addr] <= (r_regs[Rd_addr] & ~w_wr_mask) | (Rd_in & w_wr_mask);
    end
  end

  // Reserve is applied after the release so a same-edge collision leaves the bit set.
  always_comb begin
    w_pend_next = r_pending;
    if (w_wr_valid)  w_pend_next[Rd_addr]  = 1'b0;
    if (w_rsv_valid) w_pend_next[rsv_addr] = 1'b1;
    w_cnt_next = '0;
    for (int i = 0; i < NREG; i++) w_cnt_next = w_cnt_next + (ADDR_W+1)'(w_pend_next[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pending  <= w_pend_next;
      r_pend_cnt <= w_cnt_next;
    end
  end

  assign w_rs_stored     = (Rs_addr == '0) ? '0 : r_regs[Rs_addr];
  assign w_rt_stored     = (Rt_addr == '0) ? '0 : r_regs[Rt_addr];
  assign w_rs_rdy_stored = ~r_pending[Rs_addr];
  assign w_rt_rdy_stored = ~r_pending[Rt_addr];

`ifdef REGFILE_BYPASS_EN
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = w_wr_valid && (Rd_addr == Rs_addr);
  assign w_rt_hit = w_wr_valid && (Rd_addr == Rt_addr);

  assign Rs_out_wire = w_rs_hit ? ((w_rs_stored & ~w_wr_mask) | (Rd_in & w_wr_mask)) : w_rs_stored;
  assign Rt_out_wire = w_rt_hit ? ((w_rt_stored & ~w_wr_mask) | (Rd_in & w_wr_mask)) : w_rt_stored;
  // A fresh reservation on the bypassed address keeps rdy tied to the pending bit.
  assign rs_rdy = (w_rs_hit && !(w_rsv_valid && rsv_addr == Rs_addr)) ? 1'b1 : w_rs_rdy_stored;
  assign rt_rdy = (w_rt_hit && !(w_rsv_valid && rsv_addr == Rt_addr)) ? 1'b1 : w_rt_rdy_stored;
`else
  assign Rs_out_wire = w_rs_stored;
  assign Rt_out_wire = w_rt_stored;
  assign rs_rdy      = w_rs_rdy_stored;
  assign rt_rdy      = w_rt_rdy_stored;
`endif

  assign pend_cnt = r_pend_cnt;

endmodule
